// File: rtl/rom_sample_streamer_pkg.sv
// Shared types and default widths for the ROM sample streamer.
// Holds the playback state enum and a helper that classifies "busy" states.
package rom_sample_streamer_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == ST_FETCH) || (s == ST_WAIT) || (s == ST_PRESENT);
  endfunction

endpackage

// File: rtl/rom_sample_streamer_if.sv
// Bundle of the streamer's control, ROM and codec signals for bench/system wiring.
// Handshake: a sample transfers on any cycle where write (valid) and write_ready are both high.
interface rom_sample_streamer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
) (
  input logic clk
);
  logic              play;
  logic              loop;
  logic              write_ready;
  logic [DATA_W-1:0] rom_q;
  logic [ADDR_W-1:0] rom_addr;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;
  logic              busy;
  logic              done;

  modport master (
    input  clk, play, loop, write_ready, rom_q,
    output rom_addr, write, writedata_left, writedata_right, busy, done
  );

  modport slave (
    input  clk, rom_addr, write, writedata_left, writedata_right, busy, done,
    output play, loop, write_ready, rom_q
  );
endinterface

// File: rtl/sample_addr_counter.sv
// ROM address register: increments with wrap-to-zero after LAST_ADDR, clear has priority.
module sample_addr_counter #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (inc) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr    = addr_q;
  assign at_last = (addr_q == LAST_ADDR);
endmodule

// File: rtl/rom_sample_streamer.sv
// Streams samples from a 1-cycle registered ROM to an audio codec FIFO.
// One sample per FETCH/WAIT/PRESENT round; supports looping and one-shot playback.
module rom_sample_streamer
  import rom_sample_streamer_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(16'hFFFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              loop,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              busy,
  output logic              done,
  output state_t            state_dbg
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              addr_inc, addr_clr, at_last;

  sample_addr_counter #(
    .ADDR_W   (ADDR_W),
    .LAST_ADDR(LAST_ADDR)
  ) u_addr (
    .clk    (clk),
    .reset  (reset),
    .inc    (addr_inc),
    .clr    (addr_clr),
    .addr   (rom_addr),
    .at_last(at_last)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    addr_inc = 1'b0;
    addr_clr = 1'b0;
    case (state_q)
      ST_IDLE:  if (play) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        sample_d = rom_q;
        state_d  = ST_PRESENT;
      end
      ST_PRESENT: begin
        // Stall here until the codec accepts; play is only looked at on the accept cycle.
        if (write_ready) begin
          if (!at_last || loop) begin
            addr_inc = 1'b1;
            state_d  = play ? ST_FETCH : ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!play) begin
          addr_clr = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = is_busy(state_d);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign write           = (state_q == ST_PRESENT) && write_ready;
  assign writedata_left  = sample_q;
  assign writedata_right = sample_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign state_dbg       = state_q;
endmodule

// File: tb/tb_rom_sample_streamer.sv
// Bench for rom_sample_streamer with LAST_ADDR=3 and ROM[i]=24'h100000+i.
module tb_rom_sample_streamer;
  import rom_sample_streamer_pkg::*;

  localparam int            AW   = 16;
  localparam int            DW   = 24;
  localparam logic [AW-1:0] LAST = 16'd3;
  localparam logic [DW-1:0] BASE = 24'h100000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst_n;
  state_t state_dbg;

  rom_sample_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus (.clk(clk));

  rom_sample_streamer #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .LAST_ADDR(LAST)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .play           (bus.play),
    .loop           (bus.loop),
    .write_ready    (bus.write_ready),
    .rom_q          (bus.rom_q),
    .rom_addr       (bus.rom_addr),
    .write          (bus.write),
    .writedata_left (bus.writedata_left),
    .writedata_right(bus.writedata_right),
    .busy           (bus.busy),
    .done           (bus.done),
    .state_dbg      (state_dbg)
  );

  always @(posedge clk) bus.rom_q <= BASE + DW'(bus.rom_addr);

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  logic n_play, n_loop, n_wr, n_rst;

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.play        = n_play;
    bus.loop        = n_loop;
    bus.write_ready = n_wr;
    rst_n           = n_rst;
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_rst = 1'b0; n_play = 1'b0; n_loop = 1'b0; n_wr = 1'b0;
    cyc();
    cyc();
    chkv("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    chkv("reset_addr", 32'(bus.rom_addr), 32'd0);
    chkv("reset_data", 32'(bus.writedata_left), 32'd0);
    chk1("reset_write", bus.write, 1'b0);
    chk1("reset_busy", bus.busy, 1'b0);
    chk1("reset_done", bus.done, 1'b0);
  endtask

  task automatic wait_write(input int bound, input string name);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.write && n < bound);
    chk1(name, bus.write, 1'b1);
  endtask

  // ---------------- scoreboard: circular walk over ROM contents ----------------
  logic [DW-1:0] exp_q[$];
  int ptr     = 0;
  int writes  = 0;
  int since_w = 100;
  bit prev_w  = 1'b0;
  bit mon_on  = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.write) begin
        chk1("lr_equal", bus.writedata_left == bus.writedata_right, 1'b1);
        chk1("no_back_to_back", prev_w, 1'b0);
        chk1("write_spacing", since_w >= 2, 1'b1);
        if (exp_q.size() == 0) begin
          chk1("stream_queue_empty", 1'b0, 1'b1);
        end else begin
          chkv("stream_data", 32'(bus.writedata_left), 32'(exp_q.pop_front()));
        end
        ptr = (ptr == int'(LAST)) ? 0 : ptr + 1;
        exp_q.push_back(BASE + DW'(ptr));
        writes++;
        since_w = 0;
      end else begin
        since_w++;
      end
      prev_w = bus.write;
      if (!rst_n) begin
        ptr = 0;
        exp_q.delete();
        exp_q.push_back(BASE);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table for the loop-play start-up ----------------
  typedef struct {
    logic          play, loop, wr;
    logic          exp_write, exp_busy;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t tbl[18];
  int   w0;
  logic [DW-1:0] held;

  initial begin
    rst_n = 1'b0;
    bus.play = 1'b0; bus.loop = 1'b0; bus.write_ready = 1'b0;
    exp_q.push_back(BASE);

    // Row k is the k-th cycle after release with play held: a sample round every 3 cycles.
    for (int k = 0; k < 18; k++) begin
      tbl[k].play      = 1'b1;
      tbl[k].loop      = 1'b1;
      tbl[k].wr        = 1'b1;
      tbl[k].exp_write = (k >= 3) && (k % 3 == 0);
      tbl[k].exp_busy  = (k >= 1);
      tbl[k].exp_addr  = (k <= 3) ? '0 : AW'(((k - 1) / 3) % 4);
      tbl[k].exp_data  = (k < 3) ? '0 : BASE + DW'(((k / 3) - 1) % 4);
    end

    do_reset();
    mon_on = 1'b1;

    // Looping playback with an always-ready codec
    n_rst = 1'b1;
    for (int k = 0; k < 18; k++) begin
      n_play = tbl[k].play; n_loop = tbl[k].loop; n_wr = tbl[k].wr;
      cyc();
      chk1($sformatf("tbl_write[%0d]", k), bus.write, tbl[k].exp_write);
      chk1($sformatf("tbl_busy[%0d]", k), bus.busy, tbl[k].exp_busy);
      chkv($sformatf("tbl_addr[%0d]", k), 32'(bus.rom_addr), 32'(tbl[k].exp_addr));
      chkv($sformatf("tbl_data[%0d]", k), 32'(bus.writedata_left), 32'(tbl[k].exp_data));
    end

    // One-shot playback ends in DONE, cleared when play drops
    do_reset();
    n_rst = 1'b1; n_play = 1'b1; n_loop = 1'b0; n_wr = 1'b1;
    w0 = writes;
    for (int i = 0; i < 40 && !bus.done; i++) cyc();
    chk1("oneshot_done", bus.done, 1'b1);
    chkv("oneshot_writes", 32'(writes - w0), 32'd4);
    chk1("oneshot_busy", bus.busy, 1'b0);
    chkv("oneshot_addr_held", 32'(bus.rom_addr), 32'(LAST));
    cyc();
    chk1("done_stays_with_play", bus.done, 1'b1);
    chk1("done_no_write", bus.write, 1'b0);
    n_play = 1'b0;
    cyc();
    chk1("done_before_release", bus.done, 1'b1);
    cyc();
    chk1("done_cleared", bus.done, 1'b0);
    chkv("done_addr_zero", 32'(bus.rom_addr), 32'd0);
    chkv("done_to_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Codec back-pressure in PRESENT at address 1
    do_reset();
    n_rst = 1'b1; n_play = 1'b1; n_loop = 1'b1; n_wr = 1'b1;
    wait_write(10, "bp_first_write");
    chkv("bp_first_data", 32'(bus.writedata_left), 32'(BASE));
    n_wr = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 10; i++) begin
      n_play = (i % 2 == 0);
      cyc();
      chk1("bp_no_write", bus.write, 1'b0);
      chkv("bp_data_stable", 32'(bus.writedata_left), 32'(BASE + 24'd1));
      chkv("bp_addr_stable", 32'(bus.rom_addr), 32'd1);
    end
    n_play = 1'b1; n_wr = 1'b1;
    cyc();
    chk1("bp_release_write", bus.write, 1'b1);
    chkv("bp_release_data", 32'(bus.writedata_left), 32'(BASE + 24'd1));

    // Play dropped in WAIT: the pending sample still goes out, then pause
    do_reset();
    n_rst = 1'b1; n_play = 1'b1; n_loop = 1'b1; n_wr = 1'b1;
    wait_write(10, "pause_first_write");
    cyc();
    n_play = 1'b0;
    cyc();
    chkv("pause_in_wait_addr", 32'(bus.rom_addr), 32'd1);
    cyc();
    chk1("pause_pending_write", bus.write, 1'b1);
    chkv("pause_pending_data", 32'(bus.writedata_left), 32'(BASE + 24'd1));
    cyc();
    chk1("pause_idle_busy", bus.busy, 1'b0);
    chkv("pause_idle_addr", 32'(bus.rom_addr), 32'd2);
    cyc();
    chkv("pause_addr_kept", 32'(bus.rom_addr), 32'd2);
    n_play = 1'b1;
    wait_write(10, "resume_write");
    chkv("resume_data", 32'(bus.writedata_left), 32'(BASE + 24'd2));

    // Reset arriving together with an accepted write
    do_reset();
    n_rst = 1'b1; n_play = 1'b1; n_loop = 1'b1; n_wr = 1'b1;
    cyc(); cyc(); cyc();
    w0 = writes;
    n_rst = 1'b0;
    cyc();
    n_play = 1'b0;
    cyc();
    chk1("rst_mid_write_off", bus.write, 1'b0);
    chk1("rst_mid_busy", bus.busy, 1'b0);
    chk1("rst_mid_done", bus.done, 1'b0);
    chkv("rst_mid_addr", 32'(bus.rom_addr), 32'd0);
    chkv("rst_mid_data", 32'(bus.writedata_left), 32'd0);
    n_rst = 1'b1;
    cyc();
    chk1("rst_mid_single_strobe", (writes - w0) <= 1, 1'b1);
    chkv("rst_mid_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Randomized traffic against the scoreboard
    do_reset();
    w0 = writes;
    for (int i = 0; i < 3000; i++) begin
      n_play = (($urandom_range(0, 15)) != 0);
      n_loop = (($urandom_range(0, 3)) != 0);
      n_wr   = (($urandom_range(0, 2)) != 0);
      n_rst  = (($urandom_range(0, 299)) != 0);
      cyc();
      if (bus.done) begin
        chk1("rand_done_not_busy", bus.busy, 1'b0);
        chk1("rand_done_no_write", bus.write, 1'b0);
      end
      if (bus.busy && !bus.write) held = bus.writedata_left;
    end
    chk1("rand_progress", (writes - w0) > 50, 1'b1);

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_sample_streamer.md
ROM_SAMPLE_STREAMER -- requirements
Module: rom_sample_streamer

Parameters
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the sample ROM address width.
REQ-002 SHALL have parameter DATA_W, default 24, meaning the sample width, equal to the codec channel width.
REQ-003 SHALL have parameter LAST_ADDR, default 16'hFFFF, meaning the highest ROM address played before wrap or stop.

Interface
REQ-004 SHALL have port clk, input, 1, the single system clock (CLOCK_50 domain).
REQ-005 SHALL have port reset, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port play, input, 1, level request to stream samples.
REQ-007 SHALL have port loop, input, 1; 1 = wrap to address 0 after LAST_ADDR, 0 = one-shot.
REQ-008 SHALL have port write_ready, input, 1, codec DAC FIFO able to accept one sample.
REQ-009 SHALL have port rom_q, input, DATA_W, ROM read data, valid one clk after rom_addr is sampled.
REQ-010 SHALL have port rom_addr, output, ADDR_W, ROM address.
REQ-011 SHALL have port write, output, 1, one-cycle codec write strobe.
REQ-012 SHALL have port writedata_left, output, DATA_W, left sample to codec.
REQ-013 SHALL have port writedata_right, output, DATA_W, right sample to codec, always equal to writedata_left.
REQ-014 SHALL have port busy, output, 1, high in FETCH, WAIT and PRESENT.
REQ-015 SHALL have port done, output, 1, high only in DONE.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, PRESENT and DONE.
REQ-017 In IDLE with play=1, the FSM SHALL go to FETCH next cycle; with play=0 it SHALL stay in IDLE.
REQ-018 In FETCH, rom_addr SHALL be held stable and the FSM SHALL go to WAIT unconditionally.
REQ-019 At the end of WAIT, rom_q SHALL be latched into a sample register and the FSM SHALL go to PRESENT.
REQ-020 writedata_left and writedata_right SHALL be driven from the sample register and SHALL change only at the WAIT->PRESENT transition.
REQ-021 write SHALL be combinational: 1 exactly when state==PRESENT and write_ready==1; it SHALL be 0 in every other state.
REQ-022 In PRESENT with write_ready=0, the FSM SHALL hold state, address and data indefinitely, regardless of play.
REQ-023 On a write cycle with rom_addr<LAST_ADDR: address+1, then FETCH if play=1, else IDLE (pause, address kept).
REQ-024 On a write cycle with rom_addr==LAST_ADDR and loop=1: address=0, then FETCH if play=1, else IDLE.
REQ-025 On a write cycle with rom_addr==LAST_ADDR and loop=0: address held, then DONE.
REQ-026 In DONE, the FSM SHALL stay until play=0, then set address=0 and go to IDLE.
REQ-027 Throughput SHALL be one sample per 3 cycles when write_ready is held high.
REQ-028 First write SHALL occur in the third cycle after play is first sampled high in IDLE.
REQ-029 Address increment SHALL be modulo 2^ADDR_W, with no overflow beyond LAST_ADDR.
REQ-030 loop and play SHALL be sampled only at the decision points stated above.

Reset
REQ-031 While reset==0 at a clk edge, state SHALL become IDLE, rom_addr 0 and the sample register 0.
REQ-032 While reset==0 at a clk edge, write, busy and done SHALL be 0.
REQ-033 Reset asserted mid-PRESENT SHALL suppress write from the next cycle, with no partial or duplicate strobe.

Structure
REQ-034 A shared package SHALL hold the state enum and the default ADDR_W/DATA_W constants.
REQ-035 A sub-module, sample_addr_counter, SHALL own the address register, with ports inc, clr and wrap-to-zero at LAST_ADDR; the FSM stays in rom_sample_streamer.
REQ-036 The ROM model SHALL be external; the bench supplies a 1-cycle registered ROM.

Verification (LAST_ADDR=3, ROM[i]=24'h100000+i)
REQ-037 reset=0, then play=1, loop=1, write_ready=1 -> write pulses every 3 cycles, first on cycle 3, with data 100000, 100001, 100002, 100003, 100000...
REQ-038 loop=0 -> exactly 4 writes, then done=1 and busy=0; after play drops, rom_addr=0 and done=0 next cycle.
REQ-039 write_ready=0 for 10 cycles during PRESENT -> no write, writedata stable at 100001; one write on the cycle write_ready rises.
REQ-040 play drops while in WAIT at addr 1 -> the sample at addr 1 is still written, then IDLE with rom_addr=2; play re-asserted -> next write data is 100002.
REQ-041 reset=0 in the same cycle as write_ready=1 in PRESENT -> at most that one write, then IDLE, rom_addr=0, outputs 0.
REQ-042 Always checked: write never high for 2 consecutive cycles, and writedata_left==writedata_right.
